// File: rtl/act_pingpong_sram.sv
// Ping-pong activation SRAM: two DEPTH x ROW_W banks, one read by compute while the other is
// host-filled with narrow writes; a swap FSM exchanges the roles once in-flight reads drain.
module act_pingpong_sram #(
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ROW_W    = 768,
    parameter int unsigned NARROW_W = 32,
    parameter int unsigned WIDE_W   = 256,
    localparam int unsigned NN      = ROW_W / NARROW_W,
    localparam int unsigned NS      = ROW_W / WIDE_W,
    localparam int unsigned AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW      = (NN > 1) ? $clog2(NN) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ceb,
    input  logic              web,
    input  logic              wb_from_pip,
    input  logic [AW-1:0]     a_row,
    input  logic [CW-1:0]     a_col,
    input  logic [WIDE_W-1:0] d,
    input  logic              swap_req,
    output logic [ROW_W-1:0]  q,
    output logic              q_valid,
    output logic              swap_ack,
    output logic              bank_sel,
    output logic              addr_err
);

    localparam int unsigned SMASK = (1 << $clog2(NS)) - 1;

    typedef enum logic [1:0] {StIdle, StDrain, StSwap} state_e;

    state_e state_q, state_d;
    logic   bank_sel_q, bank_sel_d;
    logic   swap_ack_q, swap_ack_d;

    logic [ROW_W-1:0] mem [2][DEPTH];

    logic [CW-1:0] wide_slice;
    logic          row_ok, col_ok;
    logic          rd, wr, rd_ok, wr_ok, err;
    logic          wr_bank;

    always_comb begin
        wide_slice = a_col & CW'(SMASK);
        row_ok     = 32'(a_row) < DEPTH;
        col_ok     = wb_from_pip ? (32'(wide_slice) < NS) : (32'(a_col) < NN);
        // Accesses while in reset are dropped entirely.
        rd         = rst_n && !ceb && web;
        wr         = rst_n && !ceb && !web;
        rd_ok      = rd && row_ok;
        wr_ok      = wr && row_ok && col_ok;
        err        = (rd && !row_ok) || (wr && !(row_ok && col_ok));
        wr_bank    = wb_from_pip ? bank_sel_q : !bank_sel_q;
    end

    // Memory is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            for (int i = 0; i < NN; i++) begin
                if (!wb_from_pip && a_col == CW'(i)) begin
                    mem[wr_bank][a_row][i*NARROW_W +: NARROW_W] <= d[NARROW_W-1:0];
                end
            end
            for (int i = 0; i < NS; i++) begin
                if (wb_from_pip && wide_slice == CW'(i)) begin
                    mem[wr_bank][a_row][i*WIDE_W +: WIDE_W] <= d;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q        <= '0;
            q_valid  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            q_valid <= rd;
            if (rd_ok) begin
                q <= mem[bank_sel_q][a_row];
            end
            if (err) begin
                addr_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        bank_sel_d = bank_sel_q;
        swap_ack_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (swap_req) begin
                    state_d = rd ? StDrain : StSwap;
                end
            end
            StDrain: state_d = StSwap;
            StSwap: begin
                state_d    = StIdle;
                bank_sel_d = !bank_sel_q;
                swap_ack_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            bank_sel_q <= 1'b0;
            swap_ack_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bank_sel_q <= bank_sel_d;
            swap_ack_q <= swap_ack_d;
        end
    end

    assign bank_sel = bank_sel_q;
    assign swap_ack = swap_ack_q;

endmodule

// File: tb/tb_act_pingpong_sram.sv
// Directed bench for act_pingpong_sram: reads, narrow/wide writes, swap timing, drain, errors.
module tb_act_pingpong_sram;

    localparam int unsigned DEPTH    = 32;
    localparam int unsigned ROW_W    = 768;
    localparam int unsigned NARROW_W = 32;
    localparam int unsigned WIDE_W   = 256;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ceb, web, wb_from_pip, swap_req;
    logic [4:0]        a_row, a_col;
    logic [WIDE_W-1:0] d;
    logic [ROW_W-1:0]  q;
    logic              q_valid, swap_ack, bank_sel, addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    localparam logic [WIDE_W-1:0] P0 = {8{32'h1111_0000}};
    localparam logic [WIDE_W-1:0] P1 = {8{32'h2222_0001}};
    localparam logic [WIDE_W-1:0] P2 = {8{32'h3333_0002}};
    localparam logic [WIDE_W-1:0] Q0 = {8{32'h5A5A_0050}};
    localparam logic [WIDE_W-1:0] Q1 = {8{32'hC3C3_0051}};

    logic [ROW_W-1:0] row0_exp, row3_exp, row5_exp;

    always #5 clk = ~clk;

    act_pingpong_sram #(
        .DEPTH   (DEPTH),
        .ROW_W   (ROW_W),
        .NARROW_W(NARROW_W),
        .WIDE_W  (WIDE_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ceb        (ceb),
        .web        (web),
        .wb_from_pip(wb_from_pip),
        .a_row      (a_row),
        .a_col      (a_col),
        .d          (d),
        .swap_req   (swap_req),
        .q          (q),
        .q_valid    (q_valid),
        .swap_ack   (swap_ack),
        .bank_sel   (bank_sel),
        .addr_err   (addr_err)
    );

    task automatic idle();
        ceb = 1'b1; web = 1'b1; wb_from_pip = 1'b0; swap_req = 1'b0;
        a_row = '0; a_col = '0; d = '0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wide_wr(input logic [4:0] row, input logic [4:0] col,
                           input logic [WIDE_W-1:0] data);
        ceb = 1'b0; web = 1'b0; wb_from_pip = 1'b1; a_row = row; a_col = col; d = data;
        cyc();
        idle();
    endtask

    task automatic narrow_wr(input logic [4:0] row, input logic [4:0] col,
                             input logic [NARROW_W-1:0] data);
        ceb = 1'b0; web = 1'b0; wb_from_pip = 1'b0; a_row = row; a_col = col;
        d = WIDE_W'(data);
        cyc();
        idle();
    endtask

    task automatic rd(input logic [4:0] row);
        ceb = 1'b0; web = 1'b1; a_row = row;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        n_checks += 5;
        if (q !== '0) begin n_fail++; $display("FAIL reset_q got %h want 0", q); end
        if (q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_q_valid got %b want 0", q_valid); end
        if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL reset_swap_ack got %b want 0", swap_ack); end
        if (bank_sel !== 1'b0) begin n_fail++; $display("FAIL reset_bank_sel got %b want 0", bank_sel); end
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL reset_addr_err got %b want 0", addr_err); end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_read();
        wide_wr(5'd0, 5'd0, P0);
        wide_wr(5'd0, 5'd1, P1);
        wide_wr(5'd0, 5'd2, P2);
        rd(5'd0);
        n_checks += 2;
        if (q_valid !== 1'b1) begin n_fail++; $display("FAIL read_valid got %b want 1", q_valid); end
        if (q !== row0_exp) begin n_fail++; $display("FAIL read_row0 got %h want %h", q, row0_exp); end
        cyc();
        n_checks += 2;
        if (q_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", q_valid); end
        if (q !== row0_exp) begin n_fail++; $display("FAIL idle_hold got %h want %h", q, row0_exp); end
    endtask

    task automatic test_narrow_swap();
        for (int i = 0; i < 24; i++) narrow_wr(5'd3, 5'(i), 32'(i));
        swap_req = 1'b1;
        cyc();
        swap_req = 1'b0;
        n_checks += 2;
        if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL swap_ack_early got %b want 0", swap_ack); end
        if (bank_sel !== 1'b0) begin n_fail++; $display("FAIL bank_sel_early got %b want 0", bank_sel); end
        cyc();
        n_checks += 2;
        if (swap_ack !== 1'b1) begin n_fail++; $display("FAIL swap_ack got %b want 1", swap_ack); end
        if (bank_sel !== 1'b1) begin n_fail++; $display("FAIL bank_sel_swap got %b want 1", bank_sel); end
        cyc();
        n_checks += 2;
        if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL swap_ack_pulse got %b want 0", swap_ack); end
        if (bank_sel !== 1'b1) begin n_fail++; $display("FAIL bank_sel_hold got %b want 1", bank_sel); end
        rd(5'd3);
        n_checks++;
        if (q !== row3_exp) begin n_fail++; $display("FAIL narrow_row3 got %h want %h", q, row3_exp); end
    endtask

    task automatic test_wide();
        wide_wr(5'd5, 5'd0, Q0);
        wide_wr(5'd5, 5'd1, Q1);
        wide_wr(5'd5, 5'd2, P0);
        wide_wr(5'd5, 5'd2, '1);
        rd(5'd5);
        n_checks++;
        if (q !== row5_exp) begin n_fail++; $display("FAIL wide_row5 got %h want %h", q, row5_exp); end
    endtask

    task automatic test_drain();
        ceb = 1'b0; web = 1'b1; a_row = 5'd3; swap_req = 1'b1;
        cyc();
        n_checks += 3;
        if (q !== row3_exp) begin n_fail++; $display("FAIL drain_rd_old got %h want %h", q, row3_exp); end
        if (q_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid got %b want 1", q_valid); end
        if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL drain_ack0 got %b want 0", swap_ack); end
        a_row = 5'd5;
        cyc();
        idle();
        n_checks += 3;
        if (q !== row5_exp) begin n_fail++; $display("FAIL drain_rd_in_drain got %h want %h", q, row5_exp); end
        if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL drain_ack1 got %b want 0", swap_ack); end
        if (bank_sel !== 1'b1) begin n_fail++; $display("FAIL drain_sel1 got %b want 1", bank_sel); end
        cyc();
        n_checks += 2;
        if (swap_ack !== 1'b1) begin n_fail++; $display("FAIL drain_ack2 got %b want 1", swap_ack); end
        if (bank_sel !== 1'b0) begin n_fail++; $display("FAIL drain_sel2 got %b want 0", bank_sel); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks += 2;
            if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL no_queue_ack[%0d] got %b want 0", i, swap_ack); end
            if (bank_sel !== 1'b0) begin n_fail++; $display("FAIL no_queue_sel[%0d] got %b want 0", i, bank_sel); end
        end
        rd(5'd0);
        n_checks++;
        if (q !== row0_exp) begin n_fail++; $display("FAIL new_bank_row0 got %h want %h", q, row0_exp); end
    endtask

    task automatic test_addr_err();
        wide_wr(5'd0, 5'd3, '1);
        n_checks++;
        if (addr_err !== 1'b1) begin n_fail++; $display("FAIL addr_err_set got %b want 1", addr_err); end
        rd(5'd0);
        n_checks++;
        if (q !== row0_exp) begin n_fail++; $display("FAIL oor_no_write got %h want %h", q, row0_exp); end
        narrow_wr(5'd3, 5'd24, 32'hFFFF_FFFF);
        cyc();
        cyc();
        n_checks++;
        if (addr_err !== 1'b1) begin n_fail++; $display("FAIL addr_err_sticky got %b want 1", addr_err); end
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        n_checks++;
        if (addr_err !== 1'b0) begin n_fail++; $display("FAIL addr_err_clear got %b want 0", addr_err); end
        cyc();
    endtask

    task automatic test_reset_drain();
        swap_req = 1'b1;
        cyc();
        idle();
        cyc();
        n_checks++;
        if (bank_sel !== 1'b1) begin n_fail++; $display("FAIL rd_pre_sel got %b want 1", bank_sel); end
        ceb = 1'b0; web = 1'b1; a_row = 5'd5; swap_req = 1'b1;
        cyc();
        n_checks++;
        if (q !== row5_exp) begin n_fail++; $display("FAIL rd_pre_q got %h want %h", q, row5_exp); end
        // Fill bank is bank 0 here: this write must be dropped while in reset.
        rst_n = 1'b0;
        ceb = 1'b0; web = 1'b0; wb_from_pip = 1'b0; swap_req = 1'b0;
        a_row = 5'd0; a_col = 5'd0; d = WIDE_W'(32'hDEAD_BEEF);
        cyc();
        idle();
        rst_n = 1'b1;
        n_checks += 4;
        if (bank_sel !== 1'b0) begin n_fail++; $display("FAIL rd_abort_sel got %b want 0", bank_sel); end
        if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL rd_abort_ack got %b want 0", swap_ack); end
        if (q_valid !== 1'b0) begin n_fail++; $display("FAIL rd_abort_valid got %b want 0", q_valid); end
        if (q !== '0) begin n_fail++; $display("FAIL rd_abort_q got %h want 0", q); end
        for (int i = 0; i < 3; i++) begin
            cyc();
            n_checks += 2;
            if (swap_ack !== 1'b0) begin n_fail++; $display("FAIL rd_post_ack[%0d] got %b want 0", i, swap_ack); end
            if (bank_sel !== 1'b0) begin n_fail++; $display("FAIL rd_post_sel[%0d] got %b want 0", i, bank_sel); end
        end
        rd(5'd0);
        n_checks++;
        if (q !== row0_exp) begin n_fail++; $display("FAIL rd_mem_kept got %h want %h", q, row0_exp); end
    endtask

    initial begin
        row0_exp = {P2, P1, P0};
        row5_exp = {{WIDE_W{1'b1}}, Q1, Q0};
        for (int i = 0; i < 24; i++) row3_exp[32*i +: 32] = 32'(i);
        idle();
        rst_n = 1'b0;
        test_reset();
        test_read();
        test_narrow_swap();
        test_wide();
        test_drain();
        test_addr_err();
        test_reset_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
